// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared opcode, tag and sizing definitions for the ALU reservation station
package alu_rs_pkg;
  localparam int DATA_W = 32;
  localparam int ROB_ID_W = 4;
  localparam int RS_SIZE_DEFAULT = 16;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [DATA_W-1:0] ZERO = '0;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef enum logic [4:0] {
    NOP, OPTYPE_LUI, OPTYPE_AUIPC, OPTYPE_JAL, OPTYPE_JALR,
    OPTYPE_BEQ, OPTYPE_BNE, OPTYPE_BLT, OPTYPE_BGE, OPTYPE_BLTU, OPTYPE_BGEU,
    OPTYPE_ADDI, OPTYPE_SLTI, OPTYPE_SLTIU, OPTYPE_XORI, OPTYPE_ORI, OPTYPE_ANDI,
    OPTYPE_SLLI, OPTYPE_SRLI, OPTYPE_SRAI,
    OPTYPE_ADD, OPTYPE_SUB, OPTYPE_SLL, OPTYPE_SLT, OPTYPE_SLTU,
    OPTYPE_XOR, OPTYPE_SRL, OPTYPE_SRA, OPTYPE_OR, OPTYPE_AND
  } opcode_t;
endpackage

// File: rtl/alu_rs_lowest_sel.sv
// rs_lowest_sel: priority encoder returning the lowest set bit of a vector
module rs_lowest_sel #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (vec[i]) idx = W'(i);
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB snooping and lowest-index issue
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              issue_valid,
  input  opcode_t           issue_optype,
  input  rob_id_t           issue_rd_alias,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qj_busy,
  input  logic              issue_qk_busy,
  input  rob_id_t           issue_qj,
  input  rob_id_t           issue_qk,
  input  logic              cdb_alu_valid,
  input  rob_id_t           cdb_alu_alias,
  input  logic [DATA_W-1:0] cdb_alu_value,
  input  logic              cdb_lsb_valid,
  input  rob_id_t           cdb_lsb_alias,
  input  logic [DATA_W-1:0] cdb_lsb_value,
  output logic              full,
  output opcode_t           ex_optype,
  output rob_id_t           ex_rd_alias,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1,
  output logic [DATA_W-1:0] ex_rs2,
  output logic [DATA_W-1:0] ex_imm
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  logic [RS_SIZE-1:0] busy, qj_busy, qk_busy;
  opcode_t optype [RS_SIZE];
  rob_id_t rd_alias [RS_SIZE];
  rob_id_t qj [RS_SIZE];
  rob_id_t qk [RS_SIZE];
  logic [DATA_W-1:0] pc [RS_SIZE];
  logic [DATA_W-1:0] imm [RS_SIZE];
  logic [DATA_W-1:0] vj [RS_SIZE];
  logic [DATA_W-1:0] vk [RS_SIZE];
  logic free_found, sel_found, ins;
  logic [IW-1:0] free_idx, sel_idx;
  logic [CW-1:0] occ, occ_next;
  logic alu_j, lsb_j, alu_k, lsb_k;
  logic [DATA_W-1:0] ins_vj, ins_vk;
  rs_lowest_sel #(.N(RS_SIZE)) u_free (.vec(~busy), .found(free_found), .idx(free_idx));
  rs_lowest_sel #(.N(RS_SIZE)) u_ready (.vec(busy & ~qj_busy & ~qk_busy), .found(sel_found), .idx(sel_idx));
  always_comb begin
    ins = issue_valid & free_found;
    alu_j = issue_qj_busy & cdb_alu_valid & (cdb_alu_alias == issue_qj);
    lsb_j = issue_qj_busy & cdb_lsb_valid & (cdb_lsb_alias == issue_qj);
    alu_k = issue_qk_busy & cdb_alu_valid & (cdb_alu_alias == issue_qk);
    lsb_k = issue_qk_busy & cdb_lsb_valid & (cdb_lsb_alias == issue_qk);
    ins_vj = alu_j ? cdb_alu_value : lsb_j ? cdb_lsb_value : issue_vj;
    ins_vk = alu_k ? cdb_alu_value : lsb_k ? cdb_lsb_value : issue_vk;
    occ = '0;
    for (int i = 0; i < RS_SIZE; i++) occ = occ + CW'(busy[i]);
    occ_next = occ - CW'(sel_found) + CW'(ins);
  end
  always_ff @(posedge clk) begin
    if (rst || (rdy && clr)) begin
      busy <= '0;
      full <= FALSE;
      ex_optype <= NOP;
      ex_rd_alias <= '0;
      ex_pc <= ZERO;
      ex_rs1 <= ZERO;
      ex_rs2 <= ZERO;
      ex_imm <= ZERO;
    end else if (rdy) begin
      ex_optype <= sel_found ? optype[sel_idx] : NOP;
      if (sel_found) begin
        ex_rd_alias <= rd_alias[sel_idx];
        ex_pc <= pc[sel_idx];
        ex_rs1 <= vj[sel_idx];
        ex_rs2 <= vk[sel_idx];
        ex_imm <= imm[sel_idx];
        busy[sel_idx] <= FALSE;
      end
      full <= occ_next >= CW'(RS_SIZE - 1);
      // ALU broadcast wins if both CDBs carry the same tag
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_busy[i] && cdb_alu_valid && cdb_alu_alias == qj[i]) begin
          vj[i] <= cdb_alu_value;
          qj_busy[i] <= FALSE;
        end else if (busy[i] && qj_busy[i] && cdb_lsb_valid && cdb_lsb_alias == qj[i]) begin
          vj[i] <= cdb_lsb_value;
          qj_busy[i] <= FALSE;
        end
        if (busy[i] && qk_busy[i] && cdb_alu_valid && cdb_alu_alias == qk[i]) begin
          vk[i] <= cdb_alu_value;
          qk_busy[i] <= FALSE;
        end else if (busy[i] && qk_busy[i] && cdb_lsb_valid && cdb_lsb_alias == qk[i]) begin
          vk[i] <= cdb_lsb_value;
          qk_busy[i] <= FALSE;
        end
      end
      if (ins) begin
        busy[free_idx] <= TRUE;
        optype[free_idx] <= issue_optype;
        rd_alias[free_idx] <= issue_rd_alias;
        pc[free_idx] <= issue_pc;
        imm[free_idx] <= issue_imm;
        vj[free_idx] <= ins_vj;
        vk[free_idx] <= ins_vk;
        qj[free_idx] <= issue_qj;
        qk[free_idx] <= issue_qk;
        qj_busy[free_idx] <= issue_qj_busy & ~alu_j & ~lsb_j;
        qk_busy[free_idx] <= issue_qk_busy & ~alu_k & ~lsb_k;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed and randomized checks of alu_rs against an entry-list reference model
module tb_alu_rs;
  import alu_rs_pkg::*;
  localparam int RS = 16;
  typedef struct packed {
    logic b;
    opcode_t op;
    rob_id_t rd, qj, qk;
    logic jb, kb;
    logic [31:0] pc, imm, vj, vk;
  } ent_t;
  typedef struct packed {
    opcode_t op;
    rob_id_t rd;
    logic [31:0] pc, rs1, rs2, imm;
    logic full;
  } out_t;
  logic clk = 0, rst = 1, rdy = 1, clr = 0, issue_valid = 0;
  opcode_t issue_optype = NOP;
  rob_id_t issue_rd_alias = 0, issue_qj = 0, issue_qk = 0;
  logic [31:0] issue_pc = 0, issue_imm = 0, issue_vj = 0, issue_vk = 0;
  logic issue_qj_busy = 0, issue_qk_busy = 0;
  logic cdb_alu_valid = 0, cdb_lsb_valid = 0;
  rob_id_t cdb_alu_alias = 0, cdb_lsb_alias = 0;
  logic [31:0] cdb_alu_value = 0, cdb_lsb_value = 0;
  logic full;
  opcode_t ex_optype;
  rob_id_t ex_rd_alias;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  int total = 0, bad = 0;
  logic chk_on = 0;
  ent_t m_e [RS];
  out_t m_o;
  always #5 clk = ~clk;
  alu_rs #(.RS_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .issue_valid(issue_valid),
    .issue_optype(issue_optype), .issue_rd_alias(issue_rd_alias), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_alias(cdb_alu_alias), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_alias(cdb_lsb_alias), .cdb_lsb_value(cdb_lsb_value),
    .full(full), .ex_optype(ex_optype), .ex_rd_alias(ex_rd_alias), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // Model: pick oldest-index ready entry, drop it, append new entry to first hole, then let the CDBs wake everything still waiting
  function automatic void step(output ent_t ne [RS], output out_t no);
    int s, f, cnt;
    ne = m_e;
    no = m_o;
    if (rst || (rdy && clr)) begin
      for (int i = 0; i < RS; i++) ne[i].b = 0;
      no = '0;
      no.op = NOP;
      return;
    end
    if (!rdy) return;
    s = -1;
    f = -1;
    for (int i = RS - 1; i >= 0; i--) begin
      if (ne[i].b && !ne[i].jb && !ne[i].kb) s = i;
      if (!ne[i].b) f = i;
    end
    no.op = NOP;
    if (s >= 0) begin
      no.op = ne[s].op;
      no.rd = ne[s].rd;
      no.pc = ne[s].pc;
      no.rs1 = ne[s].vj;
      no.rs2 = ne[s].vk;
      no.imm = ne[s].imm;
      ne[s].b = 0;
    end
    if (issue_valid && f >= 0)
      ne[f] = '{b: 1, op: issue_optype, rd: issue_rd_alias, qj: issue_qj, qk: issue_qk,
                jb: issue_qj_busy, kb: issue_qk_busy, pc: issue_pc, imm: issue_imm,
                vj: issue_vj, vk: issue_vk};
    cnt = 0;
    for (int i = 0; i < RS; i++) if (ne[i].b) begin
      cnt++;
      if (ne[i].jb && cdb_alu_valid && cdb_alu_alias == ne[i].qj) begin ne[i].vj = cdb_alu_value; ne[i].jb = 0; end
      if (ne[i].jb && cdb_lsb_valid && cdb_lsb_alias == ne[i].qj) begin ne[i].vj = cdb_lsb_value; ne[i].jb = 0; end
      if (ne[i].kb && cdb_alu_valid && cdb_alu_alias == ne[i].qk) begin ne[i].vk = cdb_alu_value; ne[i].kb = 0; end
      if (ne[i].kb && cdb_lsb_valid && cdb_lsb_alias == ne[i].qk) begin ne[i].vk = cdb_lsb_value; ne[i].kb = 0; end
    end
    no.full = cnt >= RS - 1;
  endfunction
  always @(posedge clk) begin
    ent_t ne [RS];
    out_t no;
    step(ne, no);
    m_e <= ne;
    m_o <= no;
  end
  always @(negedge clk) if (chk_on) begin
    chk("m_optype", 32'(ex_optype), 32'(m_o.op));
    chk("m_rd", 32'(ex_rd_alias), 32'(m_o.rd));
    chk("m_pc", ex_pc, m_o.pc);
    chk("m_rs1", ex_rs1, m_o.rs1);
    chk("m_rs2", ex_rs2, m_o.rs2);
    chk("m_imm", ex_imm, m_o.imm);
    chk("m_full", 32'(full), 32'(m_o.full));
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(opcode_t op, rob_id_t rd, logic [31:0] vj, logic [31:0] vk, logic [31:0] imm,
                       logic jb, rob_id_t qj, logic kb, rob_id_t qk);
    issue_valid = 1;
    issue_optype = op;
    issue_rd_alias = rd;
    issue_pc = 32'h1000 + 32'(rd);
    issue_vj = vj;
    issue_vk = vk;
    issue_imm = imm;
    issue_qj_busy = jb;
    issue_qj = qj;
    issue_qk_busy = kb;
    issue_qk = qk;
  endtask
  task automatic idle();
    issue_valid = 0;
    cdb_alu_valid = 0;
    cdb_lsb_valid = 0;
  endtask
  task automatic cdb(logic alu, rob_id_t a, logic [31:0] v);
    if (alu) begin cdb_alu_valid = 1; cdb_alu_alias = a; cdb_alu_value = v; end
    else begin cdb_lsb_valid = 1; cdb_lsb_alias = a; cdb_lsb_value = v; end
  endtask
  initial begin
    for (int i = 0; i < RS; i++) m_e[i] = '0;
    m_o = '0;
    @(negedge clk);
    tick();
    chk_on = 1;
    chk("rst_op", 32'(ex_optype), 32'(NOP));
    chk("rst_full", 32'(full), 0);
    chk("rst_rs1", ex_rs1, 0);
    rst = 0;
    drive(OPTYPE_ADDI, 3, 5, 0, 7, 0, 0, 0, 0);
    tick(); idle();
    chk("addi_c2", 32'(ex_optype), 32'(NOP));
    tick();
    chk("addi_op", 32'(ex_optype), 32'(OPTYPE_ADDI));
    chk("addi_rs1", ex_rs1, 5);
    chk("addi_imm", ex_imm, 7);
    chk("addi_rd", 32'(ex_rd_alias), 3);
    tick();
    chk("addi_c4", 32'(ex_optype), 32'(NOP));
    drive(OPTYPE_ADD, 1, 0, 10, 0, 1, 4, 0, 0);
    tick(); idle(); tick(); tick();
    chk("add_park", 32'(ex_optype), 32'(NOP));
    cdb(0, 4, 20);
    tick(); idle();
    chk("add_wake", 32'(ex_optype), 32'(NOP));
    tick();
    chk("add_op", 32'(ex_optype), 32'(OPTYPE_ADD));
    chk("add_rs1", ex_rs1, 20);
    chk("add_rs2", ex_rs2, 10);
    drive(OPTYPE_SUB, 2, 0, 1, 0, 1, 6, 0, 0);
    cdb(1, 6, 9);
    tick(); idle(); tick();
    chk("sub_op", 32'(ex_optype), 32'(OPTYPE_SUB));
    chk("sub_rs1", ex_rs1, 9);
    for (int k = 0; k < 15; k++) begin
      drive(OPTYPE_ADD, rob_id_t'(k), 0, 0, 100 + k, 1, 9, 0, 0);
      tick();
      if (k == 13) chk("fill14_full", 32'(full), 0);
    end
    idle();
    chk("fill15_full", 32'(full), 1);
    cdb(1, 9, 1);
    tick(); idle();
    chk("fill_wake", 32'(ex_optype), 32'(NOP));
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("order_imm", ex_imm, 100 + k);
      if (k == 0) chk("drain_full", 32'(full), 0);
    end
    tick();
    chk("drain_nop", 32'(ex_optype), 32'(NOP));
    for (int k = 0; k < 5; k++) begin
      drive(OPTYPE_OR, rob_id_t'(k), 0, 0, k, 1, 2, 0, 0);
      tick();
    end
    drive(OPTYPE_ADDI, 7, 1, 1, 1, 0, 0, 0, 0);
    clr = 1;
    tick(); idle(); clr = 0;
    chk("clr_op", 32'(ex_optype), 32'(NOP));
    cdb(1, 2, 3);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_quiet", 32'(ex_optype), 32'(NOP));
    end
    drive(OPTYPE_XOR, 8, 0, 4, 0, 1, 5, 0, 0);
    tick(); idle();
    rdy = 0;
    cdb(1, 5, 77);
    tick(); tick(); idle(); rdy = 1;
    tick(); tick();
    chk("stall_wait", 32'(ex_optype), 32'(NOP));
    for (int k = 0; k < 3; k++) begin
      drive(OPTYPE_AND, rob_id_t'(k), 0, 0, 0, 1, 12, 0, 0);
      tick();
    end
    idle();
    rst = 1;
    tick(); rst = 0;
    chk("rst2_op", 32'(ex_optype), 32'(NOP));
    chk("rst2_full", 32'(full), 0);
    cdb(1, 5, 1);
    cdb(0, 12, 1);
    tick(); idle(); tick();
    chk("rst2_quiet", 32'(ex_optype), 32'(NOP));
    repeat (3000) begin
      rst = $urandom_range(0, 499) == 0;
      rdy = $urandom_range(0, 7) != 0;
      clr = $urandom_range(0, 79) == 0;
      issue_valid = !m_o.full && $urandom_range(0, 2) != 0;
      issue_optype = opcode_t'($urandom_range(1, 29));
      issue_rd_alias = rob_id_t'($urandom);
      issue_pc = $urandom;
      issue_imm = $urandom;
      issue_vj = $urandom;
      issue_vk = $urandom;
      issue_qj_busy = $urandom_range(0, 1) == 1;
      issue_qk_busy = $urandom_range(0, 2) == 0;
      issue_qj = rob_id_t'($urandom_range(0, 7));
      issue_qk = rob_id_t'($urandom_range(0, 7));
      cdb_alu_valid = $urandom_range(0, 2) == 0;
      cdb_alu_alias = rob_id_t'($urandom_range(0, 7));
      cdb_alu_value = $urandom;
      cdb_lsb_valid = $urandom_range(0, 2) == 0;
      cdb_lsb_alias = rob_id_t'($urandom_range(0, 7));
      cdb_lsb_value = $urandom;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
